// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader.
// Optional abort feature: FIFO_BURST_READER_ABORT_EN.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_burst_skid.sv
// Two-entry output buffer between FIFO read data and stream.
// Head entry drives the stream; tail absorbs one extra word.
module fifo_burst_skid
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  flush,
  output occ_t                  occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // occupancy holds; shift and refill
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ != 2'd0);
  assign dout  = head;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a 1-cycle-latency FIFO onto a stream.
// Define FIFO_BURST_READER_ABORT_EN to add abort/aborted ports.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
`ifdef FIFO_BURST_READER_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  state_t               state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] issued;
  logic [LEN_WIDTH-1:0] sent;
  logic                 inflight;
  logic                 hs;
  logic                 abort_run;
  logic                 push;
  logic [2:0]           load;
  occ_t                 occ;

`ifdef FIFO_BURST_READER_ABORT_EN
  logic aborted_q;
  assign abort_run = abort && (state == RUN);
  assign aborted   = aborted_q;
`else
  assign abort_run = 1'b0;
`endif

  assign hs   = m_valid && m_ready;
  // words that will sit in the buffer after this edge
  assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, hs};
  assign push = inflight && (state == RUN);

  assign fifo_r_en = (state == RUN) && !fifo_empty
                  && (issued < len)
                  && (load < 3'(SKID_DEPTH))
                  && !abort_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
`ifdef FIFO_BURST_READER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      inflight <= fifo_r_en;
      unique case (state)
        IDLE: begin
          if (start) begin
            len    <= burst_len;
            issued <= '0;
            sent   <= '0;
            state  <= (burst_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fifo_r_en) issued <= issued + 1'b1;
          if (hs)        sent   <= sent + 1'b1;
          if (abort_run) begin
            state <= DONE;
`ifdef FIFO_BURST_READER_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else if (hs && (LEN_WIDTH'(sent + 1'b1) == len)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef FIFO_BURST_READER_ABORT_EN
          aborted_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  fifo_burst_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_data_out),
    .pop   (hs),
    .flush (abort_run),
    .occ   (occ),
    .valid (m_valid),
    .dout  (m_data)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a FIFO model
// and an in-order scoreboard over the popped word sequence.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_data_out = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_BURST_READER_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:1023];
  int rp = 0;
  int wp = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
`ifdef FIFO_BURST_READER_ABORT_EN
    .abort         (abort),
    .aborted       (aborted),
`endif
    .fifo_empty    (fifo_empty),
    .fifo_r_en     (fifo_r_en),
    .fifo_data_out (fifo_data_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
  );

  // FIFO model: registered read data, one cycle after r_en
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_r_en && (wp != rp)) begin
      fifo_data_out <= mem[rp % 1024];
      rp <= rp + 1;
    end
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [7:0] d);
    mem[wp % 1024] = d;
    wp++;
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall 5 cycles
  task automatic run_burst(int len, int mode, int preload,
                           int push_at, bit exp_gap,
                           bit do_rst, bit exp_tput);
    int base, acc, pops, cyc, pending, stall_n;
    int first_hs, last_hs, first_pop, last_pop;
    bit fin, stalled, saw_gap;
    logic [7:0] hold_d;
    acc = 0; pops = 0; cyc = 0; stall_n = 0;
    first_hs = -1; last_hs = -1;
    first_pop = -1; last_pop = -1;
    fin = 0; stalled = 0; saw_gap = 0; hold_d = 0;
    for (int i = 0; i < preload; i++) push(8'($urandom));
    @(negedge clk);
    pending = len - (wp - rp);
    if (pending < 0) pending = 0;
    start = 1'b1;
    burst_len = 8'(len);
    base = rp;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (do_rst && acc >= 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_out",
              {busy, done, m_valid, fifo_r_en, m_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (pending > 0) begin
        if ((push_at < 0 && $urandom_range(0, 1) != 0) ||
            (push_at >= 0 && cyc >= push_at)) begin
          push(8'($urandom));
          pending--;
        end
      end
      case (mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          m_ready = !(acc >= 1 && stall_n < 5);
          if (!m_ready) stall_n++;
        end
        default: m_ready = 1'b1;
      endcase
      #1;
      if (cyc == 1) check("busy", busy, 1);
      if (stalled)
        check("hold", {m_valid, m_data}, {1'b1, hold_d});
      if (fifo_r_en) begin
        check("ren_empty", fifo_empty, 0);
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (m_valid && m_ready) begin
        check("data", m_data, mem[(base + acc) % 1024]);
        acc++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (fifo_r_en) check("outst", (pops - acc) <= 2, 1);
      if (acc > 0 && acc < len && !m_valid && !done)
        saw_gap = 1;
      stalled = m_valid && !m_ready;
      hold_d  = m_data;
      if (done) begin
        fin = 1;
        if (len == 0) check("done_t", cyc, 1);
        else          check("done_t", cyc - last_hs, 1);
        check("n_acc", acc, len);
        check("n_pop", pops, len);
      end
    end
    if (!fin) begin
      check("timeout", 0, 1);
      return;
    end
    @(negedge clk);
    #1;
    check("idle", {busy, done}, 0);
    if (exp_gap) check("gap", saw_gap, 1);
    if (exp_tput) begin
      check("hs_rate", last_hs - first_hs, len - 1);
      check("pop_rate", last_pop - first_pop, len - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    burst_len = 8'd0;
    m_ready = 1'b0;
`ifdef FIFO_BURST_READER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset",
          {busy, done, m_valid, fifo_r_en, m_data}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    run_burst(4, 0, 0, -1, 0, 0, 1);

    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    run_burst(4, 2, 0, -1, 0, 0, 0);

    run_burst(3, 0, 1, 4, 1, 0, 0);

    run_burst(0, 0, 0, -1, 0, 0, 0);

    run_burst(6, 0, 6, -1, 0, 1, 0);
    run_burst(2, 0, 0, -1, 0, 0, 0);

    for (int t = 0; t < 12; t++) begin
      int len;
      len = $urandom_range(1, 8);
      run_burst(len, 1, $urandom_range(0, len), -1, 0, 0, 0);
    end

`ifdef FIFO_BURST_READER_ABORT_EN
    begin
      int acc, cyc;
      acc = 0; cyc = 0;
      for (int i = 0; i < 6; i++) push(8'($urandom));
      @(negedge clk);
      start = 1'b1;
      burst_len = 8'd6;
      m_ready = 1'b1;
      while (acc < 2 && cyc < 50) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        #1;
        if (m_valid && m_ready) acc++;
      end
      if (acc < 2) check("ab_timeout", 0, 1);
      @(negedge clk);
      abort = 1'b1;
      m_ready = 1'b0;
      #1;
      check("ab_ren", fifo_r_en, 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("ab_pulse", {m_valid, done, aborted}, 3'b011);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        check("ab_quiet", {fifo_r_en, busy, aborted}, 0);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
